// File: rtl/j_pwmseq.sv
// DAC PWM sequencer: buffers one offset-binary sample, runs the prescaled
// 8-bit phase counter, and presents phase/compare/stop to the pulse stage.
module j_pwmseq #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic [15:0]      sdata,
    input  logic             svalid,
    output logic             sready,
    input  logic             clr_underrun,
    output logic [7:0]       a,
    output logic [6:0]       b,
    output logic             stop,
    output logic             underrun
);

    logic [DIV_W-1:0] pcnt_reg, pcnt_next;
    logic [7:0]       a_reg, a_next;
    logic [6:0]       b_reg, b_next;
    logic [6:0]       hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic             sready_reg, sready_next;
    logic             stop_reg, stop_next;
    logic             underrun_reg, underrun_next;
    logic             tick, boundary, transfer;

    // '>=' rather than '==' so that lowering div mid-count never forces a full wrap.
    assign tick     = enable && (pcnt_reg >= div);
    assign boundary = tick && (a_reg == 8'hFF);
    assign transfer = svalid && sready_reg;

    always_comb begin
        pcnt_next      = pcnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        underrun_next  = underrun_reg;

        if (!enable) begin
            pcnt_next = '0;
            a_next    = 8'h00;
        end else if (tick) begin
            pcnt_next = '0;
            a_next    = a_reg + 8'd1;
        end else begin
            pcnt_next = pcnt_reg + 1'b1;
        end

        // Transfer and boundary load are mutually exclusive: sready is low while full.
        if (transfer) begin
            hold_next      = {~sdata[15], sdata[14:9]};
            hold_full_next = 1'b1;
        end

        if (clr_underrun) begin
            underrun_next = 1'b0;
        end

        if (boundary) begin
            if (hold_full_reg) begin
                b_next         = hold_reg;
                hold_full_next = 1'b0;
            end else begin
                underrun_next  = 1'b1;
            end
        end

        stop_next   = a_next[7] | ~enable;
        sready_next = ~hold_full_next;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            pcnt_reg      <= '0;
            a_reg         <= 8'h00;
            b_reg         <= 7'h40;
            hold_reg      <= 7'h00;
            hold_full_reg <= 1'b0;
            sready_reg    <= 1'b1;
            stop_reg      <= 1'b1;
            underrun_reg  <= 1'b0;
        end else begin
            pcnt_reg      <= pcnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            sready_reg    <= sready_next;
            stop_reg      <= stop_next;
            underrun_reg  <= underrun_next;
        end
    end

    assign a        = a_reg;
    assign b        = b_reg;
    assign stop     = stop_reg;
    assign sready   = sready_reg;
    assign underrun = underrun_reg;

endmodule
